// File: rtl/sram_arbiter.sv
// Shares one 512Kx8 SRAM between video fetches (priority) and CPU accesses.
// Optional stall-cycle counter enabled by SRAM_ARB_CONTEND_CNT_EN.
//   state | meaning
//   IDLE  | no access, arbitrate
//   VRD1  | video address on bus
//   VRD2  | video data sampled, arbitrate
//   CRD1  | CPU read address on bus
//   CRD2  | CPU data sampled, arbitrate
//   CWR1  | CPU write address/data driven
//   CWR2  | write strobe low
//   CWR3  | strobe released, data held, arbitrate
module sram_arbiter #(
    parameter logic [2:0] SCR_PAGE_NORMAL = 3'd5,
    parameter logic [2:0] SCR_PAGE_SHADOW = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] cpu_addr,
    input  logic        cpu_oe_n,
    input  logic        cpu_we_n,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait_n,
    input  logic        vrampage,
    input  logic        vid_req,
    input  logic [12:0] vid_ofs,
    output logic [7:0]  vid_data,
    output logic        vid_ack,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_i,
    output logic        sram_we_n
`ifdef SRAM_ARB_CONTEND_CNT_EN
    ,
    input  logic        contend_clr,
    output logic [15:0] contend_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, VRD1, VRD2, CRD1, CRD2, CWR1, CWR2, CWR3} state_t;

    state_t      state_q, state_d;
    logic [18:0] sram_addr_q, sram_addr_d;
    logic [7:0]  sram_dq_o_q, sram_dq_o_d;
    logic        sram_dq_oe_q, sram_dq_oe_d;
    logic        sram_we_n_q, sram_we_n_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic [7:0]  vid_data_q, vid_data_d;
    logic        vid_ack_q, vid_ack_d;
    logic        vid_pend_q, vid_pend_d;
    logic [18:0] vid_addr_q, vid_addr_d;
    logic        rd_served_q, rd_served_d;
    logic        wr_served_q, wr_served_d;

    logic [18:0] vid_new, vid_addr_sel;
    logic        rd_req, wr_req, arb_state, vid_go, wr_go, rd_go;

    assign vid_new      = {2'b00, (vrampage ? SCR_PAGE_SHADOW : SCR_PAGE_NORMAL), 1'b0, vid_ofs};
    assign vid_addr_sel = vid_pend_q ? vid_addr_q : vid_new;

    assign rd_req    = !cpu_oe_n && cpu_we_n && !rd_served_q;
    assign wr_req    = !cpu_oe_n && !cpu_we_n && !wr_served_q;
    assign arb_state = (state_q == IDLE) || (state_q == VRD2) ||
                       (state_q == CRD2) || (state_q == CWR3);

    // A request completing in this very slot must not win its own follow-up slot.
    assign vid_go = vid_pend_q || vid_req;
    assign wr_go  = wr_req && (state_q != CWR3);
    assign rd_go  = rd_req && (state_q != CRD2);

    assign cpu_wait_n = !((rd_req || wr_req) &&
                          ((state_q == VRD1) || (state_q == VRD2) || (arb_state && vid_pend_q)));

    always_comb begin
        state_d     = state_q;
        sram_addr_d = sram_addr_q;
        sram_dq_o_d = sram_dq_o_q;
        cpu_dout_d  = cpu_dout_q;
        vid_data_d  = vid_data_q;
        vid_ack_d   = (state_q == VRD2);
        vid_pend_d  = vid_pend_q;
        vid_addr_d  = vid_addr_q;
        rd_served_d = rd_served_q;
        wr_served_d = wr_served_q;

        if (vid_req && !vid_pend_q) begin
            vid_pend_d = 1'b1;
            vid_addr_d = vid_new;
        end
        if (state_q == VRD1)
            vid_pend_d = 1'b0;

        if (cpu_oe_n) begin
            rd_served_d = 1'b0;
            wr_served_d = 1'b0;
        end else begin
            if (state_q == CRD2) rd_served_d = 1'b1;
            if (state_q == CWR3) wr_served_d = 1'b1;
        end

        if (state_q == VRD2) vid_data_d = sram_dq_i;
        if (state_q == CRD2) cpu_dout_d = sram_dq_i;

        case (state_q)
            VRD1:    state_d = VRD2;
            CRD1:    state_d = CRD2;
            CWR1:    state_d = CWR2;
            CWR2:    state_d = CWR3;
            default: begin
                if (vid_go)     state_d = VRD1;
                else if (wr_go) state_d = CWR1;
                else if (rd_go) state_d = CRD1;
                else            state_d = IDLE;
            end
        endcase

        if (state_d == VRD1) sram_addr_d = vid_addr_sel;
        if (state_d == CRD1) sram_addr_d = cpu_addr;
        if (state_d == CWR1) begin
            sram_addr_d = cpu_addr;
            sram_dq_o_d = cpu_din;
        end
        sram_dq_oe_d = (state_d == CWR1) || (state_d == CWR2) || (state_d == CWR3);
        sram_we_n_d  = (state_d != CWR2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sram_addr_q  <= '0;
            sram_dq_o_q  <= '0;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            cpu_dout_q   <= 8'hFF;
            vid_data_q   <= '0;
            vid_ack_q    <= 1'b0;
            vid_pend_q   <= 1'b0;
            vid_addr_q   <= '0;
            rd_served_q  <= 1'b0;
            wr_served_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sram_addr_q  <= sram_addr_d;
            sram_dq_o_q  <= sram_dq_o_d;
            sram_dq_oe_q <= sram_dq_oe_d;
            sram_we_n_q  <= sram_we_n_d;
            cpu_dout_q   <= cpu_dout_d;
            vid_data_q   <= vid_data_d;
            vid_ack_q    <= vid_ack_d;
            vid_pend_q   <= vid_pend_d;
            vid_addr_q   <= vid_addr_d;
            rd_served_q  <= rd_served_d;
            wr_served_q  <= wr_served_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = sram_dq_o_q;
    assign sram_dq_oe = sram_dq_oe_q;
    assign sram_we_n  = sram_we_n_q;
    assign cpu_dout   = cpu_dout_q;
    assign vid_data   = vid_data_q;
    assign vid_ack    = vid_ack_q;

`ifdef SRAM_ARB_CONTEND_CNT_EN
    logic [15:0] contend_cnt_q, contend_cnt_d;

    always_comb begin
        contend_cnt_d = contend_cnt_q;
        if (contend_clr)
            contend_cnt_d = '0;
        else if (!cpu_wait_n && (contend_cnt_q != 16'hFFFF))
            contend_cnt_d = contend_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) contend_cnt_q <= '0;
        else     contend_cnt_q <= contend_cnt_d;
    end

    assign contend_cnt = contend_cnt_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] cpu_addr;
    logic        cpu_oe_n, cpu_we_n;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_wait_n;
    logic        vrampage, vid_req;
    logic [12:0] vid_ofs;
    logic [7:0]  vid_data;
    logic        vid_ack;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_ARB_CONTEND_CNT_EN
    logic        contend_clr;
    logic [15:0] contend_cnt;
`endif

    int checks = 0;
    int passes = 0;
    int we_pulses = 0;
    int we_low_cycles = 0;
    int ack_cnt = 0;

    logic [7:0] mem [0:524287];

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
        .vrampage(vrampage), .vid_req(vid_req), .vid_ofs(vid_ofs),
        .vid_data(vid_data), .vid_ack(vid_ack),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
`ifdef SRAM_ARB_CONTEND_CNT_EN
        , .contend_clr(contend_clr), .contend_cnt(contend_cnt)
`endif
    );

    assign sram_dq_i = mem[sram_addr];

    always @(posedge sram_we_n) if (sram_dq_oe && !rst) mem[sram_addr] = sram_dq_o;
    always @(negedge sram_we_n) if (!rst) we_pulses++;
    always @(negedge clk) begin
        if (!sram_we_n) we_low_cycles++;
        if (vid_ack) ack_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(2);
        checks++; if (sram_addr !== 19'h0) $display("FAIL rst_addr: got %h want 0", sram_addr); else passes++;
        checks++; if (sram_dq_o !== 8'h00) $display("FAIL rst_dq_o: got %h want 00", sram_dq_o); else passes++;
        checks++; if (sram_dq_oe !== 1'b0) $display("FAIL rst_dq_oe: got %b want 0", sram_dq_oe); else passes++;
        checks++; if (sram_we_n !== 1'b1) $display("FAIL rst_we_n: got %b want 1", sram_we_n); else passes++;
        checks++; if (cpu_dout !== 8'hFF) $display("FAIL rst_cpu_dout: got %h want FF", cpu_dout); else passes++;
        checks++; if (vid_data !== 8'h00) $display("FAIL rst_vid_data: got %h want 00", vid_data); else passes++;
        checks++; if (vid_ack !== 1'b0) $display("FAIL rst_vid_ack: got %b want 0", vid_ack); else passes++;
        checks++; if (cpu_wait_n !== 1'b1) $display("FAIL rst_wait_n: got %b want 1", cpu_wait_n); else passes++;
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_cpu_read;
        mem[19'h14000] = 8'hA5;
        cpu_addr = 19'h14000;
        cpu_oe_n = 1'b0;
        checks++; if (cpu_wait_n !== 1'b1) $display("FAIL rd_wait_idle: got %b want 1", cpu_wait_n); else passes++;
        tick(1);
        checks++; if (sram_addr !== 19'h14000) $display("FAIL rd_addr: got %h want 14000", sram_addr); else passes++;
        checks++; if (sram_dq_oe !== 1'b0) $display("FAIL rd_dq_oe: got %b want 0", sram_dq_oe); else passes++;
        checks++; if (cpu_wait_n !== 1'b1) $display("FAIL rd_wait_crd1: got %b want 1", cpu_wait_n); else passes++;
        tick(2);
        checks++; if (cpu_dout !== 8'hA5) $display("FAIL rd_data: got %h want A5", cpu_dout); else passes++;
        mem[19'h14000] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++; if (cpu_wait_n !== 1'b1) $display("FAIL rd_wait_hold%0d: got %b want 1", i, cpu_wait_n); else passes++;
        end
        checks++; if (cpu_dout !== 8'hA5) $display("FAIL rd_no_reread: got %h want A5", cpu_dout); else passes++;
        cpu_oe_n = 1'b1;
        tick(2);
    endtask

    task automatic test_write_late_we;
        mem[19'h0A123] = 8'h77;
        we_pulses = 0;
        we_low_cycles = 0;
        cpu_addr = 19'h0A123;
        cpu_din  = 8'h3C;
        cpu_oe_n = 1'b0;
        cpu_we_n = 1'b1;
        tick(2);
        cpu_we_n = 1'b0;
        tick(1);
        checks++; if (cpu_dout !== 8'h77) $display("FAIL wr_read_slot: got %h want 77", cpu_dout); else passes++;
        checks++; if (sram_addr !== 19'h0A123) $display("FAIL wr_addr: got %h want 0A123", sram_addr); else passes++;
        checks++; if (sram_dq_o !== 8'h3C) $display("FAIL wr_dq_o: got %h want 3C", sram_dq_o); else passes++;
        checks++; if (sram_dq_oe !== 1'b1) $display("FAIL wr_oe_cwr1: got %b want 1", sram_dq_oe); else passes++;
        checks++; if (sram_we_n !== 1'b1) $display("FAIL wr_we_cwr1: got %b want 1", sram_we_n); else passes++;
        tick(1);
        checks++; if (sram_we_n !== 1'b0) $display("FAIL wr_we_cwr2: got %b want 0", sram_we_n); else passes++;
        checks++; if (sram_dq_oe !== 1'b1) $display("FAIL wr_oe_cwr2: got %b want 1", sram_dq_oe); else passes++;
        tick(1);
        checks++; if (sram_we_n !== 1'b1) $display("FAIL wr_we_cwr3: got %b want 1", sram_we_n); else passes++;
        checks++; if (sram_dq_oe !== 1'b1) $display("FAIL wr_oe_cwr3: got %b want 1", sram_dq_oe); else passes++;
        checks++; if (sram_dq_o !== 8'h3C) $display("FAIL wr_dq_hold: got %h want 3C", sram_dq_o); else passes++;
        tick(1);
        checks++; if (sram_dq_oe !== 1'b0) $display("FAIL wr_oe_after: got %b want 0", sram_dq_oe); else passes++;
        tick(4);
        checks++; if (we_pulses !== 1) $display("FAIL wr_pulse_count: got %0d want 1", we_pulses); else passes++;
        checks++; if (we_low_cycles !== 1) $display("FAIL wr_pulse_width: got %0d want 1", we_low_cycles); else passes++;
        checks++; if (mem[19'h0A123] !== 8'h3C) $display("FAIL wr_mem: got %h want 3C", mem[19'h0A123]); else passes++;
        cpu_oe_n = 1'b1;
        cpu_we_n = 1'b1;
        tick(2);
    endtask

    // Video fetch and CPU read raised in the same idle cycle.
    task automatic test_collision;
        mem[19'h1D800] = 8'hC3;
        mem[19'h03210] = 8'h96;
        ack_cnt  = 0;
        vid_ofs  = 13'h1800;
        vrampage = 1'b1;
        vid_req  = 1'b1;
        cpu_addr = 19'h03210;
        cpu_oe_n = 1'b0;
        tick(1);
        vid_req = 1'b0;
        checks++; if (sram_addr !== 19'h1D800) $display("FAIL col_vaddr: got %h want 1D800", sram_addr); else passes++;
        checks++; if (cpu_wait_n !== 1'b0) $display("FAIL col_wait_vrd1: got %b want 0", cpu_wait_n); else passes++;
        checks++; if (vid_ack !== 1'b0) $display("FAIL col_ack_vrd1: got %b want 0", vid_ack); else passes++;
        tick(1);
        checks++; if (cpu_wait_n !== 1'b0) $display("FAIL col_wait_vrd2: got %b want 0", cpu_wait_n); else passes++;
        checks++; if (vid_ack !== 1'b0) $display("FAIL col_ack_vrd2: got %b want 0", vid_ack); else passes++;
        tick(1);
        checks++; if (vid_ack !== 1'b1) $display("FAIL col_ack: got %b want 1", vid_ack); else passes++;
        checks++; if (vid_data !== 8'hC3) $display("FAIL col_vdata: got %h want C3", vid_data); else passes++;
        checks++; if (sram_addr !== 19'h03210) $display("FAIL col_caddr: got %h want 03210", sram_addr); else passes++;
        checks++; if (cpu_wait_n !== 1'b1) $display("FAIL col_wait_crd1: got %b want 1", cpu_wait_n); else passes++;
        tick(2);
        checks++; if (cpu_dout !== 8'h96) $display("FAIL col_cdata: got %h want 96", cpu_dout); else passes++;
        checks++; if (ack_cnt !== 1) $display("FAIL col_ack_count: got %0d want 1", ack_cnt); else passes++;
        cpu_oe_n = 1'b1;
        tick(2);
    endtask

    task automatic test_overrun;
        mem[19'h14000] = 8'h4B;
        mem[19'h14001] = 8'hD2;
        ack_cnt  = 0;
        vrampage = 1'b0;
        vid_ofs  = 13'h0000;
        vid_req  = 1'b1;
        tick(1);
        vid_ofs  = 13'h0001;
        checks++; if (sram_addr !== 19'h14000) $display("FAIL ovr_addr: got %h want 14000", sram_addr); else passes++;
        tick(1);
        vid_req = 1'b0;
        tick(1);
        checks++; if (vid_data !== 8'h4B) $display("FAIL ovr_vdata: got %h want 4B", vid_data); else passes++;
        tick(4);
        checks++; if (ack_cnt !== 1) $display("FAIL ovr_ack_count: got %0d want 1", ack_cnt); else passes++;
        checks++; if (sram_addr !== 19'h14000) $display("FAIL ovr_no_second: got %h want 14000", sram_addr); else passes++;
    endtask

    task automatic test_reset_mid_write;
        cpu_addr = 19'h00055;
        cpu_din  = 8'hE1;
        cpu_oe_n = 1'b0;
        cpu_we_n = 1'b0;
        tick(2);
        checks++; if (sram_we_n !== 1'b0) $display("FAIL mrst_pre_we: got %b want 0", sram_we_n); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if (sram_we_n !== 1'b1) $display("FAIL mrst_we_n: got %b want 1", sram_we_n); else passes++;
        checks++; if (sram_dq_oe !== 1'b0) $display("FAIL mrst_dq_oe: got %b want 0", sram_dq_oe); else passes++;
        cpu_oe_n = 1'b1;
        cpu_we_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        checks++; if (cpu_dout !== 8'hFF) $display("FAIL mrst_cpu_dout: got %h want FF", cpu_dout); else passes++;
        checks++; if (sram_addr !== 19'h0) $display("FAIL mrst_idle_addr: got %h want 0", sram_addr); else passes++;
        checks++; if (sram_dq_oe !== 1'b0) $display("FAIL mrst_idle_oe: got %b want 0", sram_dq_oe); else passes++;
    endtask

`ifdef SRAM_ARB_CONTEND_CNT_EN
    task automatic test_contend_cnt;
        contend_clr = 1'b1;
        tick(1);
        contend_clr = 1'b0;
        checks++; if (contend_cnt !== 16'd0) $display("FAIL cnt_clr0: got %0d want 0", contend_cnt); else passes++;
        for (int i = 0; i < 3; i++) begin
            vid_ofs  = 13'h0010;
            vrampage = 1'b0;
            vid_req  = 1'b1;
            cpu_addr = 19'h00200;
            cpu_oe_n = 1'b0;
            tick(1);
            vid_req = 1'b0;
            tick(4);
            cpu_oe_n = 1'b1;
            tick(2);
        end
        checks++; if (contend_cnt !== 16'd6) $display("FAIL cnt_value: got %0d want 6", contend_cnt); else passes++;
        contend_clr = 1'b1;
        tick(1);
        contend_clr = 1'b0;
        checks++; if (contend_cnt !== 16'd0) $display("FAIL cnt_clr: got %0d want 0", contend_cnt); else passes++;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        cpu_addr = '0;
        cpu_oe_n = 1'b1;
        cpu_we_n = 1'b1;
        cpu_din  = '0;
        vrampage = 1'b0;
        vid_req  = 1'b0;
        vid_ofs  = '0;
`ifdef SRAM_ARB_CONTEND_CNT_EN
        contend_clr = 1'b0;
`endif
        test_reset();
        test_cpu_read();
        test_write_late_we();
        test_collision();
        test_overrun();
        test_reset_mid_write();
`ifdef SRAM_ARB_CONTEND_CNT_EN
        test_contend_cnt();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
